// File: rtl/fn_cero_if.sv
// Operand/flag bundle for the zero-detect unit.
//   a       operand under test             (master -> slave)
//   en      flag-bank capture enable       (master -> slave)
//   Y       combinational zero flag        (slave -> master)
//   y_q     registered zero flag           (slave -> master)
//   ones_q  registered all-ones flag       (slave -> master)
//   neg_q   registered sign flag           (slave -> master)
//   lzc_q   registered leading-zero count  (slave -> master)
//   tzc_q   registered trailing-zero count (slave -> master)
interface fn_cero_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 6
);
  logic [WIDTH-1:0] a;
  logic             en;
  logic             Y;
  logic             y_q;
  logic             ones_q;
  logic             neg_q;
  logic [CW-1:0]    lzc_q;
  logic [CW-1:0]    tzc_q;

  modport master (
    output a, en,
    input  Y, y_q, ones_q, neg_q, lzc_q, tzc_q
  );

  modport slave (
    input  a, en,
    output Y, y_q, ones_q, neg_q, lzc_q, tzc_q
  );
endinterface

// File: rtl/fn_cero.sv
// Zero-detect / operand-flag unit for the RV32I datapath.
// Y is a purely combinational zero flag on bus.a. Alongside it a flag bank
// captures zero, all-ones, sign, leading-zero and trailing-zero counts on a
// rising clk edge when bus.en is high.
//   clk  system clock
//   rst  synchronous active-high reset, priority over en
//   bus  fn_cero_if slave: a/en in; Y, y_q, ones_q, neg_q, lzc_q, tzc_q out
module fn_cero #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 6
) (
  input  logic      clk,
  input  logic      rst,
  fn_cero_if.slave  bus
);

  if (WIDTH < 2) begin : g_bad_width
    $error("fn_cero: WIDTH must be at least 2");
  end
  if (CW != $clog2(WIDTH) + 1) begin : g_bad_cw
    $error("fn_cero: CW must equal clog2(WIDTH)+1");
  end

  // Reduction NOR: any known 1 forces 0, otherwise unknown bits give X.
  assign bus.Y = ~|bus.a;

  logic          zero;
  logic          ones;
  logic          neg;
  logic [CW-1:0] lzc;
  logic [CW-1:0] tzc;

  assign zero = ~|bus.a;
  assign ones = &bus.a;
  assign neg  = bus.a[WIDTH-1];

  // Priority chains: the last matching bit wins, so scanning upward leaves
  // the highest set bit for lzc and scanning downward the lowest for tzc.
  always_comb begin
    lzc = CW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bus.a[i]) lzc = CW'(WIDTH - 1 - i);
    end
  end

  always_comb begin
    tzc = CW'(WIDTH);
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (bus.a[i]) tzc = CW'(i);
    end
  end

  logic          zero_q, zero_d;
  logic          ones_q, ones_d;
  logic          neg_q,  neg_d;
  logic [CW-1:0] lzc_q,  lzc_d;
  logic [CW-1:0] tzc_q,  tzc_d;

  always_comb begin
    zero_d = zero_q;
    ones_d = ones_q;
    neg_d  = neg_q;
    lzc_d  = lzc_q;
    tzc_d  = tzc_q;
    if (bus.en) begin
      zero_d = zero;
      ones_d = ones;
      neg_d  = neg;
      lzc_d  = lzc;
      tzc_d  = tzc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      ones_q <= 1'b0;
      neg_q  <= 1'b0;
      lzc_q  <= '0;
      tzc_q  <= '0;
    end else begin
      zero_q <= zero_d;
      ones_q <= ones_d;
      neg_q  <= neg_d;
      lzc_q  <= lzc_d;
      tzc_q  <= tzc_d;
    end
  end

  assign bus.y_q    = zero_q;
  assign bus.ones_q = ones_q;
  assign bus.neg_q  = neg_q;
  assign bus.lzc_q  = lzc_q;
  assign bus.tzc_q  = tzc_q;

endmodule

// File: tb/tb_fn_cero.sv
// Self-checking bench for fn_cero: directed corner cases plus randomized
// operands against an arithmetic reference model of the flag bank.
module tb_fn_cero;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CW    = 6;

  logic clk;
  logic rst;
  logic clk_run;

  fn_cero_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  fn_cero #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: expected registered flags.
  logic          m_zero, m_ones, m_neg;
  logic [CW-1:0] m_lzc, m_tzc;

  function automatic int ref_lzc(input logic [31:0] v);
    // Highest set bit position is clog2(v+1)-1; yields 32 for v == 0.
    longint unsigned w;
    w = longint'(v) + 1;
    return 32 - $clog2(w);
  endfunction

  function automatic int ref_tzc(input logic [31:0] v);
    // Bits below the lowest set bit; v == 0 wraps to all ones -> 32.
    logic [31:0] low;
    low = (v & (~v + 32'd1)) - 32'd1;
    return $countones(low);
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".Y"},      64'(bus.Y),      64'(bus.a == '0));
    check({tag, ".y_q"},    64'(bus.y_q),    64'(m_zero));
    check({tag, ".ones_q"}, 64'(bus.ones_q), 64'(m_ones));
    check({tag, ".neg_q"},  64'(bus.neg_q),  64'(m_neg));
    check({tag, ".lzc_q"},  64'(bus.lzc_q),  64'(m_lzc));
    check({tag, ".tzc_q"},  64'(bus.tzc_q),  64'(m_tzc));
  endtask

  // Apply inputs, advance one edge, update the model, then check.
  task automatic tick(input logic r, input logic e, input logic [31:0] v, input string tag);
    rst    = r;
    bus.en = e;
    bus.a  = v;
    @(posedge clk);
    if (r) begin
      m_zero = 0; m_ones = 0; m_neg = 0; m_lzc = '0; m_tzc = '0;
    end else if (e) begin
      m_zero = (v == 32'd0);
      m_ones = (v == 32'hFFFF_FFFF);
      m_neg  = v[31];
      m_lzc  = CW'(ref_lzc(v));
      m_tzc  = CW'(ref_tzc(v));
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk     = 0;
    clk_run = 0;
    rst     = 0;
    bus.en  = 0;

    // Y with no clock or reset activity.
    bus.a = 32'd0;
    for (int i = 0; i < 5; i++) begin
      #10;
      check("noclk_zero.Y", 64'(bus.Y), 64'd1);
    end
    bus.a = 32'd1;
    #1;
    check("noclk_one.Y", 64'(bus.Y), 64'd0);
    for (int i = 0; i < 5; i++) begin
      #10;
      check("noclk_one_hold.Y", 64'(bus.Y), 64'd0);
    end

    clk_run = 1;
    @(negedge clk);

    tick(1'b1, 1'b1, 32'hFFFF_FFFF, "rst0");
    tick(1'b1, 1'b1, 32'hFFFF_FFFF, "rst1");

    tick(1'b0, 1'b1, 32'h0000_0000, "zero");
    check("zero.lzc32", 64'(bus.lzc_q), 64'd32);
    check("zero.tzc32", 64'(bus.tzc_q), 64'd32);
    tick(1'b0, 1'b1, 32'h0000_0001, "one");
    check("one.lzc31", 64'(bus.lzc_q), 64'd31);
    tick(1'b0, 1'b1, 32'h8000_0000, "msb");
    check("msb.tzc31", 64'(bus.tzc_q), 64'd31);
    tick(1'b0, 1'b1, 32'hFFFF_FFFF, "ones");
    check("ones.ones_q", 64'(bus.ones_q), 64'd1);

    tick(1'b0, 1'b1, 32'h00F0_0000, "mid");
    check("mid.lzc8", 64'(bus.lzc_q), 64'd8);
    check("mid.tzc20", 64'(bus.tzc_q), 64'd20);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0000_0000, "hold");
      check("hold.lzc8", 64'(bus.lzc_q), 64'd8);
      check("hold.Y1", 64'(bus.Y), 64'd1);
    end

    // Reset wins over enable mid-stream.
    tick(1'b0, 1'b1, 32'h1234_5678, "pre_rst");
    tick(1'b1, 1'b1, 32'h0000_0000, "rst_en");
    check("rst_en.y_q0", 64'(bus.y_q), 64'd0);
    tick(1'b0, 1'b1, 32'h0000_0000, "post_rst");

    for (int i = 0; i < 300; i++) begin
      logic [31:0] v;
      logic        r, e;
      int          sh;
      v  = $urandom;
      sh = $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0: v = v >> sh;
        1: v = v << sh;
        2: v = (v >> sh) << $urandom_range(0, 31);
        default: ;
      endcase
      if ($urandom_range(0, 31) == 0) v = 32'd0;
      r = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 7) != 0);
      tick(r, e, v, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fn_cero.md
Name: fn_cero

Overview:
- Zero-detect / operand-flag unit for the RV32I datapath (ALU result flags, BEQ/BNE decision support).
- Main output Y is purely combinational: Y = 1 when the 32-bit operand `a` is all zeros.
- A registered flag bank sits next to Y. It captures zero, all-ones, sign, leading-zero count and trailing-zero count for use in the following pipeline stage.

Parameters:
- WIDTH, 32, operand width in bits. Must be ≥ 2. RV32I uses 32.
- CW, 6, width of the count outputs. Must equal clog2(WIDTH)+1 so that the value WIDTH is representable.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand under test.
- en  input  1  capture enable for the registered flag bank.
- Y  output  1  combinational zero flag: 1 iff a == 0.
- y_q  output  1  registered zero flag.
- ones_q  output  1  registered all-ones flag: 1 iff every bit of a is 1.
- neg_q  output  1  registered sign flag, equal to a[WIDTH-1].
- lzc_q  output  CW  registered count of leading zeros, counted from the MSB.
- tzc_q  output  CW  registered count of trailing zeros, counted from the LSB.

Behaviour:
- Y:
  - Pure combinational reduction; there is no clock or reset dependence.
  - Valid within the same delta/time step as any change of a.
  - Must work even when clk is never toggled and rst is never asserted.
- Y handling of unknowns: if a contains X/Z bits, Y = 0 when any known bit is 1; otherwise Y is X.
- Registered bank, on each rising clk edge:
  - rst = 1: y_q = 0, ones_q = 0, neg_q = 0, lzc_q = 0, tzc_q = 0. Reset has priority over en.
  - rst = 0, en = 1: all registered outputs load the flags computed from the current a.
  - rst = 0, en = 0: all registered outputs hold their values.
- Latency:
  - Registered outputs: 1 cycle from the edge that samples a with en = 1.
  - Y: 0 cycles.
- Count rules:
  - lzc = number of consecutive 0 bits starting at bit WIDTH-1. tzc = the same starting at bit 0.
  - a == 0 → lzc = tzc = WIDTH (32), and y_q = 1.
  - a == all ones → lzc = tzc = 0, ones_q = 1, neg_q = 1.
  - a == 1 → lzc = 31, tzc = 0.
  - a == 0x80000000 → lzc = 0, tzc = 31, neg_q = 1.
- Consistency: y_q and ones_q are never both 1. y_q = 1 implies lzc_q = tzc_q = WIDTH.
- Counters must be built as parameterised priority/tree logic. No behavioural loops that depend on simulation time.
- Reset mid-operation: a rst pulse clears the bank on that edge. Capture resumes on the next edge with en = 1. Y is unaffected throughout.

Test Plan:
- a = 0, no clock activity, observe for 50 time units → Y = 1 continuously. Then a = 1 → Y = 0 in the same time step, held for 50 time units.
- rst = 1 for 2 cycles with a = 0xFFFFFFFF and en = 1 → all registered outputs 0. Y = 0 throughout.
- en = 1, a = 0 → next edge: y_q = 1, ones_q = 0, neg_q = 0, lzc_q = 32, tzc_q = 32.
- en = 1, apply in sequence:
  - a = 0x00000001 → lzc_q = 31, tzc_q = 0, y_q = 0.
  - a = 0x80000000 → lzc_q = 0, tzc_q = 31, neg_q = 1.
  - a = 0xFFFFFFFF → ones_q = 1, lzc_q = 0, tzc_q = 0.
- Load a = 0x00F00000 with en = 1 → lzc_q = 8, tzc_q = 20. Then en = 0 and a = 0 for 3 cycles → registers hold 8/20, y_q stays 0, while Y = 1.
- Random 32-bit a values with en = 1, compared against a reference model → Y and every registered flag match each cycle. Also assert rst on a cycle where en = 1 → reset wins.
